// File: rtl/up5bit_counter_arbiter.sv
// -----------------------------------------------------------------------------
// up5bit_counter_arbiter
//
// Shares one WIDTH-bit up counter between two requesters with round-robin
// arbitration. The winner's target is latched at grant. The counter then runs
// from 0 up to that target, and a one-cycle done pulse goes to the owner.
// The owner can drop its request mid-job to abort; no done is issued then.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   req0/1   - level requests from requester 0/1
//   target0/1- terminal count per requester, sampled only at grant
//   gnt0/1   - requester owns the counter (registered)
//   done0/1  - one-cycle job-complete pulse (registered)
//   count    - shared counter value (registered)
//   busy     - high whenever the arbiter is not idle (registered)
// -----------------------------------------------------------------------------
module up5bit_counter_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] target0,
    input  logic             req1,
    input  logic [WIDTH-1:0] target1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             prio_q,   prio_d;   // requester favoured on a tie
    logic             owner_q,  owner_d;  // requester holding the counter
    logic             gnt0_q,   gnt0_d;
    logic             gnt1_q,   gnt1_d;
    logic             done0_q,  done0_d;
    logic             done1_q,  done1_d;
    logic             busy_q,   busy_d;

    logic             winner;
    logic             owner_req;

    // On a tie the pointer decides; otherwise whichever request is high wins.
    assign winner    = (req0 && req1) ? prio_q : req1;
    assign owner_req = owner_q ? req1 : req0;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        busy_d   = busy_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req0 || req1) begin
                    state_d  = COUNT;
                    owner_d  = winner;
                    count_d  = '0;
                    target_d = winner ? target1 : target0;
                    gnt0_d   = ~winner;
                    gnt1_d   = winner;
                    busy_d   = 1'b1;
                end
            end

            COUNT: begin
                busy_d = 1'b1;
                // Abort is checked first so a dropped request never yields done.
                if (!owner_req) begin
                    state_d = IDLE;
                    count_d = '0;
                    busy_d  = 1'b0;
                end else if (count_q == target_q) begin
                    state_d = DONE;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                    gnt0_d  = ~owner_q;
                    gnt1_d  = owner_q;
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                prio_d  = ~owner_q;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign count = count_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_up5bit_counter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_up5bit_counter_arbiter
//
// Directed bench for up5bit_counter_arbiter. Inputs change 1 ns after each
// rising edge and outputs are sampled at that point, so every check sees the
// registers loaded by the preceding edge.
// -----------------------------------------------------------------------------
module tb_up5bit_counter_arbiter;

    logic       clk;
    logic       reset;
    logic       req0;
    logic [4:0] target0;
    logic       req1;
    logic [4:0] target1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [4:0] count;
    logic       busy;

    int vectors;
    int miscompares;

    up5bit_counter_arbiter #(.WIDTH(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .target0(target0),
        .req1   (req1),
        .target1(target1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .count  (count),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {gnt0,gnt1,done0,done1,busy,count} against the expected tuple.
    task automatic chk(input string tag, input logic g0, input logic g1,
                       input logic d0, input logic d1, input logic b,
                       input logic [4:0] cnt);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {gnt0, gnt1, done0, done1, busy, count};
        exp = {g0, g1, d0, d1, b, cnt};
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed g0g1d0d1b_cnt=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        chk("rst_state", 0, 0, 0, 0, 0, 5'd0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        target0 = 5'd0;
        target1 = 5'd0;

        #12;
        chk("rst_initial", 0, 0, 0, 0, 0, 5'd0);
        step();
        reset = 1'b1;
        step();
        chk("idle_no_req", 0, 0, 0, 0, 0, 5'd0);

        // Single job, requester 0, target 3.
        req0 = 1'b1; target0 = 5'd3;
        step(); chk("t3_c0", 1, 0, 0, 0, 1, 5'd0);
        step(); chk("t3_c1", 1, 0, 0, 0, 1, 5'd1);
        step(); chk("t3_c2", 1, 0, 0, 0, 1, 5'd2);
        step(); chk("t3_c3", 1, 0, 0, 0, 1, 5'd3);
        step(); chk("t3_done", 0, 0, 1, 0, 1, 5'd3);
        req0 = 1'b0;
        step(); chk("t3_idle", 0, 0, 0, 0, 0, 5'd3);
        step(); chk("t3_stay_idle", 0, 0, 0, 0, 0, 5'd3);

        // Contention from a fresh pointer: 0 first, then 1, then 0 again.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; target0 = 5'd2; target1 = 5'd5;
        step(); chk("rr_g0_c0", 1, 0, 0, 0, 1, 5'd0);
        step(); chk("rr_g0_c1", 1, 0, 0, 0, 1, 5'd1);
        step(); chk("rr_g0_c2", 1, 0, 0, 0, 1, 5'd2);
        step(); chk("rr_done0", 0, 0, 1, 0, 1, 5'd2);
        step(); chk("rr_gap_idle", 0, 0, 0, 0, 0, 5'd2);
        for (int i = 0; i <= 5; i++) begin
            step(); chk("rr_g1_cnt", 0, 1, 0, 0, 1, 5'(i));
        end
        step(); chk("rr_done1", 0, 0, 0, 1, 1, 5'd5);
        step(); chk("rr_gap_idle2", 0, 0, 0, 0, 0, 5'd5);
        step(); chk("rr_g0_again", 1, 0, 0, 0, 1, 5'd0);
        req0 = 1'b0; req1 = 1'b0;
        step(); chk("rr_abort", 0, 0, 0, 0, 0, 5'd0);

        // Requester 1: target 0, then target 31 without wrap.
        req1 = 1'b1; target1 = 5'd0;
        step(); chk("t0_gnt1", 0, 1, 0, 0, 1, 5'd0);
        step(); chk("t0_done1", 0, 0, 0, 1, 1, 5'd0);
        target1 = 5'd31;
        step(); chk("t31_idle", 0, 0, 0, 0, 0, 5'd0);
        step(); chk("t31_c0", 0, 1, 0, 0, 1, 5'd0);
        for (int i = 1; i <= 31; i++) begin
            step(); chk("t31_cnt", 0, 1, 0, 0, 1, 5'(i));
        end
        step(); chk("t31_done1", 0, 0, 0, 1, 1, 5'd31);
        req1 = 1'b0;
        step(); chk("t31_idle_hold", 0, 0, 0, 0, 0, 5'd31);
        step(); chk("t31_no_wrap", 0, 0, 0, 0, 0, 5'd31);

        // Abort by requester 0 at count 4 with requester 1 pending.
        req0 = 1'b1; req1 = 1'b1; target0 = 5'd10; target1 = 5'd2;
        step(); chk("ab_c0", 1, 0, 0, 0, 1, 5'd0);
        for (int i = 1; i <= 4; i++) begin
            step(); chk("ab_cnt", 1, 0, 0, 0, 1, 5'(i));
        end
        req0 = 1'b0;
        step(); chk("ab_idle", 0, 0, 0, 0, 0, 5'd0);
        step(); chk("ab_pending_g1", 0, 1, 0, 0, 1, 5'd0);
        req1 = 1'b0;
        step(); chk("ab_g1_abort", 0, 0, 0, 0, 0, 5'd0);

        // Target change during grant is ignored; leaves pointer at 1.
        req0 = 1'b1; target0 = 5'd3;
        step(); chk("tc_c0", 1, 0, 0, 0, 1, 5'd0);
        target0 = 5'd20;
        step(); chk("tc_c1", 1, 0, 0, 0, 1, 5'd1);
        step(); chk("tc_c2", 1, 0, 0, 0, 1, 5'd2);
        step(); chk("tc_c3", 1, 0, 0, 0, 1, 5'd3);
        step(); chk("tc_done0", 0, 0, 1, 0, 1, 5'd3);
        req0 = 1'b0;
        step(); chk("tc_idle", 0, 0, 0, 0, 0, 5'd3);

        // Asynchronous reset mid-job, then pointer back at requester 0.
        req0 = 1'b1; req1 = 1'b1; target0 = 5'd15; target1 = 5'd15;
        step(); chk("ar_g1_c0", 0, 1, 0, 0, 1, 5'd0);
        for (int i = 1; i <= 7; i++) begin
            step(); chk("ar_cnt", 0, 1, 0, 0, 1, 5'(i));
        end
        #2;
        reset = 1'b0;
        #1;
        chk("ar_async_clear", 0, 0, 0, 0, 0, 5'd0);
        step();
        chk("ar_held", 0, 0, 0, 0, 0, 5'd0);
        reset = 1'b1;
        step(); chk("ar_prio_reset_g0", 1, 0, 0, 0, 1, 5'd0);
        req0 = 1'b0; req1 = 1'b0;
        step(); chk("ar_final_abort", 0, 0, 0, 0, 0, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/up5bit_counter_arbiter.md
Name: up5bit_counter_arbiter

Overview:
Shares one 5-bit up counter between two requesters using a round-robin scheme.
- Each requester presents a terminal count and holds a level request.
- The arbiter grants one requester, runs the shared counter from 0 up to that requester's latched target, then pulses done to the owner.
- Sits between requester logic and the counter datapath, and serialises all count jobs onto one counter.

Parameters:
WIDTH, 5, width of counter, target inputs and count output.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0); sole reset.
req0  input  1  requester 0 level request; held high until done0 or abort.
target0  input  WIDTH  requester 0 terminal count; sampled at grant only.
req1  input  1  requester 1 level request.
target1  input  WIDTH  requester 1 terminal count.
gnt0  output  1  requester 0 owns the counter.
gnt1  output  1  requester 1 owns the counter.
done0  output  1  one-cycle pulse: requester 0 job completed.
done1  output  1  one-cycle pulse: requester 1 job completed.
count  output  WIDTH  shared counter value.
busy  output  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state=IDLE, count=0, gnt0/gnt1/done0/done1/busy=0, target_lat=0, round-robin pointer prio=0 (requester 0 favoured). Applies immediately, including mid-job; the job is discarded and no done is issued.
- States are IDLE, COUNT and DONE.
- IDLE:
  - No req: state stays IDLE and count holds.
  - Exactly one req high: that requester wins.
  - Both req high: requester prio wins.
  - Next edge after a win: state=COUNT, gnt_winner=1, count=0, target_lat=target_winner, busy=1.
  - Latency is req high → gnt high: 1 cycle.
- COUNT:
  - If req_owner=0, abort: next edge state=IDLE, gnt=0, count=0, no done, prio unchanged.
  - Else if count==target_lat: next edge state=DONE, gnt_owner=0, done_owner=1, count holds the final value.
  - Else count increments by 1.
  - Abort has priority over completion in the same cycle.
- DONE:
  - Lasts exactly one cycle.
  - Next edge: state=IDLE, done=0, busy=0, prio=other requester.
- Cycle counts: gnt stays high for target_lat+1 cycles (count shows 0..target_lat), then done pulses once.
- target 0: gnt is high 1 cycle with count=0, then done.
- target 31: count reaches 31 and never wraps. count never exceeds target_lat, so no overflow logic is required.
- Target changes while granted are ignored because the target is latched at grant.
- Non-owner req during a job waits. It is arbitrated in the IDLE cycle after DONE or abort. Grant gap between jobs: 2 cycles (DONE, IDLE).
- If the owner keeps req high after done, it is a new request. Round-robin still favours the other requester if both are high.
- gnt0 and gnt1 are never high together. done0 and done1 are never high together. done is never high together with the same requester's gnt.

Test Plan:
- After reset release, req0=1, target0=3 → gnt0 high 4 cycles with count 0,1,2,3, then done0 for 1 cycle with count=3, then busy=0; req0 dropped after done0.
- req0=req1=1 in the same IDLE cycle, target0=2, target1=5 → gnt0 first (prio=0) and done0. Then after DONE+IDLE, gnt1 with count 0..5 and done1. Then, with both still high, gnt0 again (round-robin).
- req1=1, target1=0 → gnt1 for 1 cycle with count=0, then done1; target1=31 → count reaches 31, done1, no wrap to 0.
- req0=1, target0=10, drop req0 when count=4 → next cycle gnt0=0, count=0, no done0, state IDLE; pending req1 is granted the following cycle.
- Assert reset=0 asynchronously mid-job at count=7 (between clock edges) → gnt/done/busy/count go to 0 immediately. After release, with both req high, requester 0 wins (prio reset).
- Change target0 from 3 to 20 while gnt0 is high → done0 still occurs at count=3.
